// File: rtl/alu_seq_ctrl.sv
// Command sequencer around a 4-slice bit-sliced ALU: single-pass ops in EXEC,
// MUL as an alternating add/shift loop reusing the same slices.
module alu_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               res_cout,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Slice select lines s3..s0: s3:s2 = group, s1:s0 = function within group.
  typedef enum logic [3:0] {
    FN_ADD  = 4'b0000,
    FN_SUB  = 4'b0001,
    FN_AND  = 4'b0100,
    FN_OR   = 4'b0101,
    FN_XOR  = 4'b0110,
    FN_SHL  = 4'b1000,
    FN_SHR  = 4'b1001,
    FN_PASS = 4'b1100
  } alu_fn_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_EXEC, ST_MUL_ADD, ST_MUL_SHIFT, ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     phi_q, phi_d;
  logic [WIDTH-1:0]     plo_q, plo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 carry_q, carry_d;
  logic [2*WIDTH-1:0]   res_data_q, res_data_d;
  logic                 res_cout_q, res_cout_d;

  alu_fn_e              alu_fn;
  logic [WIDTH-1:0]     alu_a, alu_b, alu_y;
  logic                 alu_cin, alu_shr_fill, alu_cout;
  logic [WIDTH:0]       carry_w;
  logic [WIDTH-1:0]     ail_w, air_w;

  assign carry_w[0] = alu_cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slice
      logic b_eff;
      assign b_eff = alu_fn[0] & (alu_fn[3:2] == 2'b00) ? ~alu_b[gi] : alu_b[gi];
      if (gi == 0) begin : g_lsb
        assign ail_w[gi] = 1'b0;
      end else begin : g_mid_l
        assign ail_w[gi] = alu_a[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_msb
        assign air_w[gi] = alu_shr_fill;
      end else begin : g_mid_r
        assign air_w[gi] = alu_a[gi+1];
      end
      assign carry_w[gi+1] = (alu_a[gi] & b_eff) | (alu_a[gi] & carry_w[gi])
                           | (b_eff & carry_w[gi]);
      always_comb begin
        unique case (alu_fn)
          FN_ADD, FN_SUB: alu_y[gi] = alu_a[gi] ^ b_eff ^ carry_w[gi];
          FN_AND:         alu_y[gi] = alu_a[gi] & alu_b[gi];
          FN_OR:          alu_y[gi] = alu_a[gi] | alu_b[gi];
          FN_XOR:         alu_y[gi] = alu_a[gi] ^ alu_b[gi];
          FN_SHL:         alu_y[gi] = ail_w[gi];
          FN_SHR:         alu_y[gi] = air_w[gi];
          default:        alu_y[gi] = alu_a[gi];
        endcase
      end
    end
  endgenerate

  always_comb begin
    unique case (alu_fn)
      FN_ADD, FN_SUB: alu_cout = carry_w[WIDTH];
      FN_SHL:         alu_cout = alu_a[WIDTH-1];
      FN_SHR:         alu_cout = alu_a[0];
      default:        alu_cout = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    phi_d        = phi_q;
    plo_d        = plo_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    res_data_d   = res_data_q;
    res_cout_d   = res_cout_q;
    alu_fn       = FN_PASS;
    alu_a        = a_q;
    alu_b        = b_q;
    alu_cin      = 1'b0;
    alu_shr_fill = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          phi_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          if (cmd_op == OP_MUL) begin
            plo_d   = cmd_b;
            state_d = ST_MUL_ADD;
          end else begin
            plo_d   = '0;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        unique case (op_q)
          OP_ADD:  alu_fn = FN_ADD;
          OP_SUB:  begin alu_fn = FN_SUB; alu_cin = 1'b1; end
          OP_AND:  alu_fn = FN_AND;
          OP_OR:   alu_fn = FN_OR;
          OP_XOR:  alu_fn = FN_XOR;
          OP_SHL:  alu_fn = FN_SHL;
          OP_SHR:  alu_fn = FN_SHR;
          default: alu_fn = FN_PASS;
        endcase
        res_data_d = {{WIDTH{1'b0}}, alu_y};
        res_cout_d = alu_cout;
        state_d    = ST_DONE;
      end
      ST_MUL_ADD: begin
        alu_a  = phi_q;
        alu_b  = a_q;
        alu_fn = plo_q[0] ? FN_ADD : FN_PASS;
        phi_d   = alu_y;
        carry_d = plo_q[0] & alu_cout;
        state_d = ST_MUL_SHIFT;
      end
      ST_MUL_SHIFT: begin
        // Carry from the add re-enters at the top; P_hi's LSB drops into P_lo.
        alu_a        = phi_q;
        alu_fn       = FN_SHR;
        alu_shr_fill = carry_q;
        phi_d        = alu_y;
        plo_d        = {phi_q[0], plo_q[WIDTH-1:1]};
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          res_data_d = {alu_y, phi_q[0], plo_q[WIDTH-1:1]};
          res_cout_d = 1'b0;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_MUL_ADD;
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      phi_q      <= '0;
      plo_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      res_data_q <= '0;
      res_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      phi_q      <= phi_d;
      plo_q      <= plo_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      res_data_q <= res_data_d;
      res_cout_q <= res_cout_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = res_data_q;
  assign res_cout  = res_cout_q;

endmodule
